// File: rtl/block_dispatcher_pkg.sv
// Shared state encodings and width helpers for the kernel block dispatcher.
package gpu_dispatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} top_state_e;

  typedef enum logic [1:0] {C_IDLE, C_RESET, C_RUN} slot_state_e;

  // Block counters carry one extra bit so ceil(thread_count/THREADS_PER_BLOCK) never wraps.
  function automatic int block_count_w(int tc_bits);
    return tc_bits + 1;
  endfunction

endpackage

// File: rtl/block_dispatcher_if.sv
// Launch-side and core-side signals of the block dispatcher, grouped as one bus.
interface block_dispatcher_if #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_BITS           = 8
);
  localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                start;
  logic [TC_BITS-1:0]                  thread_count;
  logic                                done;
  logic [NUM_CORES-1:0]                core_reset;
  logic [NUM_CORES-1:0]                core_start;
  logic [NUM_CORES-1:0][TC_BITS-1:0]   core_block_id;
  logic [NUM_CORES-1:0][CNT_W-1:0]     core_thread_count;
  logic [NUM_CORES-1:0]                core_done;

  modport master (
    output start, thread_count, core_done,
    input  done, core_reset, core_start, core_block_id, core_thread_count
  );

  modport slave (
    input  start, thread_count, core_done,
    output done, core_reset, core_start, core_block_id, core_thread_count
  );
endinterface

// File: rtl/block_dispatcher_slot.sv
// One core's sequencer: reset pulse, then start held until the core reports done.
module dispatch_slot
  import gpu_dispatch_pkg::*;
#(
  parameter int TC_BITS = 8,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               assign_stb,
  input  logic [TC_BITS-1:0] id,
  input  logic [CNT_W-1:0]   count,
  input  logic               core_done,
  output logic               core_reset,
  output logic               core_start,
  output logic [TC_BITS-1:0] block_id,
  output logic [CNT_W-1:0]   thread_count,
  output logic               free,
  output logic               retire
);
  slot_state_e state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= C_IDLE;
      core_reset   <= 1'b0;
      core_start   <= 1'b0;
      block_id     <= '0;
      thread_count <= '0;
    end else begin
      case (state)
        C_IDLE: if (assign_stb) begin
          state        <= C_RESET;
          core_reset   <= 1'b1;
          block_id     <= id;
          thread_count <= count;
        end
        C_RESET: begin
          state      <= C_RUN;
          core_reset <= 1'b0;
          core_start <= 1'b1;
        end
        C_RUN: if (core_done) begin
          state      <= C_IDLE;
          core_start <= 1'b0;
        end
        default: state <= C_IDLE;
      endcase
    end
  end

  // Free is taken from the registered state, so a slot retiring this edge is not reused until the next.
  assign free   = (state == C_IDLE);
  assign retire = (state == C_RUN) && core_done;
endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel launch into fixed-size blocks and hands them to the core slots in index order.
module block_dispatcher
  import gpu_dispatch_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_BITS           = 8
) (
  input  logic               clk,
  input  logic               reset,
  block_dispatcher_if.slave  bus
);
  localparam int LOG2  = $clog2(THREADS_PER_BLOCK);
  localparam int CNT_W = LOG2 + 1;
  localparam int BLK_W = block_count_w(TC_BITS);

  top_state_e                        state;
  logic [TC_BITS-1:0]                tc;
  logic [BLK_W-1:0]                  total;
  logic [BLK_W-1:0]                  dispatched;
  logic [BLK_W-1:0]                  retired;
  logic                              done;

  logic [NUM_CORES-1:0]              free;
  logic [NUM_CORES-1:0]              grant;
  logic [NUM_CORES-1:0]              retire;
  logic [NUM_CORES-1:0]              assign_stb;
  logic [NUM_CORES-1:0]              core_reset_v;
  logic [NUM_CORES-1:0]              core_start_v;
  logic [NUM_CORES-1:0][TC_BITS-1:0] block_id_v;
  logic [NUM_CORES-1:0][CNT_W-1:0]   count_v;
  logic [BLK_W-1:0]                  comp;
  logic [BLK_W-1:0]                  rem;
  logic [CNT_W-1:0]                  next_count;
  logic                              do_dispatch;

  function automatic logic [BLK_W-1:0] ceil_blocks(input logic [TC_BITS-1:0] n);
    return (BLK_W'(n) + BLK_W'(THREADS_PER_BLOCK - 1)) >> LOG2;
  endfunction

  // Isolate the lowest set bit: the lowest-index idle slot wins.
  assign grant       = free & (~free + NUM_CORES'(1));
  assign do_dispatch = (state == RUN) && (dispatched < total) && (|free);
  assign assign_stb  = do_dispatch ? grant : '0;

  assign rem        = BLK_W'(tc) - (dispatched << LOG2);
  assign next_count = (rem >= BLK_W'(THREADS_PER_BLOCK)) ? CNT_W'(THREADS_PER_BLOCK)
                                                         : rem[CNT_W-1:0];

  always_comb begin
    comp = '0;
    for (int i = 0; i < NUM_CORES; i++) comp = comp + BLK_W'(retire[i]);
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_slot #(.TC_BITS(TC_BITS), .CNT_W(CNT_W)) u_slot (
      .clk          (clk),
      .reset        (reset),
      .assign_stb   (assign_stb[g]),
      .id           (dispatched[TC_BITS-1:0]),
      .count        (next_count),
      .core_done    (bus.core_done[g]),
      .core_reset   (core_reset_v[g]),
      .core_start   (core_start_v[g]),
      .block_id     (block_id_v[g]),
      .thread_count (count_v[g]),
      .free         (free[g]),
      .retire       (retire[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tc         <= '0;
      total      <= '0;
      dispatched <= '0;
      retired    <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          tc         <= bus.thread_count;
          total      <= ceil_blocks(bus.thread_count);
          dispatched <= '0;
          retired    <= '0;
          if (bus.thread_count == '0) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (do_dispatch) dispatched <= dispatched + BLK_W'(1);
          retired <= retired + comp;
          if (retired + comp == total) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: if (!bus.start) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done              = done;
  assign bus.core_reset        = core_reset_v;
  assign bus.core_start        = core_start_v;
  assign bus.core_block_id     = block_id_v;
  assign bus.core_thread_count = count_v;
endmodule

// File: tb/tb_block_dispatcher.sv
// Directed scenarios for block_dispatcher with two cores and four threads per block.
module tb_block_dispatcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  block_dispatcher_if #(.NUM_CORES(2), .THREADS_PER_BLOCK(4), .TC_BITS(8)) bus ();

  block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4), .TC_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] n);
    bus.start = 1'b1;
    bus.thread_count = n;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.thread_count = 8'd0;
    bus.core_done = 2'b00;
    reset = 1'b0;
    step();
    step();
    vectors++;
    if ({bus.done, bus.core_reset, bus.core_start} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 00000", {bus.done, bus.core_reset, bus.core_start});
    end
    vectors++;
    if ({bus.core_block_id, bus.core_thread_count} !== 22'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {bus.core_block_id, bus.core_thread_count});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_full_blocks();
    launch(8'd8);
    step();
    vectors++;
    if (bus.core_reset !== 2'b01 || bus.core_block_id[0] !== 8'd0 || bus.core_thread_count[0] !== 3'd4) begin
      miscompares++;
      $display("FAIL full_e1: got rst=%b id=%0d cnt=%0d required rst=01 id=0 cnt=4",
               bus.core_reset, bus.core_block_id[0], bus.core_thread_count[0]);
    end
    step();
    vectors++;
    if (bus.core_reset !== 2'b10 || bus.core_start !== 2'b01 ||
        bus.core_block_id[1] !== 8'd1 || bus.core_thread_count[1] !== 3'd4) begin
      miscompares++;
      $display("FAIL full_e2: got rst=%b st=%b id=%0d cnt=%0d required rst=10 st=01 id=1 cnt=4",
               bus.core_reset, bus.core_start, bus.core_block_id[1], bus.core_thread_count[1]);
    end
    step();
    vectors++;
    if (bus.core_reset !== 2'b00 || bus.core_start !== 2'b11) begin
      miscompares++;
      $display("FAIL full_e3: got rst=%b st=%b required rst=00 st=11", bus.core_reset, bus.core_start);
    end
    for (int i = 0; i < 6; i++) step();
    bus.core_done = 2'b11;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.done !== 1'b1 || bus.core_start !== 2'b00) begin
      miscompares++;
      $display("FAIL full_done: got done=%b st=%b required done=1 st=00", bus.done, bus.core_start);
    end
    step();
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL full_idle: got done=%b required 0", bus.done);
    end
  endtask

  task automatic test_partial_block();
    launch(8'd10);
    step();
    step();
    step();
    bus.core_done = 2'b01;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.core_start !== 2'b10 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL part_free0: got st=%b done=%b required st=10 done=0", bus.core_start, bus.done);
    end
    step();
    vectors++;
    if (bus.core_reset !== 2'b01 || bus.core_block_id[0] !== 8'd2 || bus.core_thread_count[0] !== 3'd2) begin
      miscompares++;
      $display("FAIL part_blk2: got rst=%b id=%0d cnt=%0d required rst=01 id=2 cnt=2",
               bus.core_reset, bus.core_block_id[0], bus.core_thread_count[0]);
    end
    step();
    vectors++;
    if (bus.core_start !== 2'b11 || bus.core_reset !== 2'b00) begin
      miscompares++;
      $display("FAIL part_run: got st=%b rst=%b required st=11 rst=00", bus.core_start, bus.core_reset);
    end
    bus.core_done = 2'b10;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.done !== 1'b0 || bus.core_start !== 2'b01) begin
      miscompares++;
      $display("FAIL part_early: got done=%b st=%b required done=0 st=01", bus.done, bus.core_start);
    end
    bus.core_done = 2'b01;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL part_done: got done=%b required 1", bus.done);
    end
    step();
  endtask

  task automatic test_zero_threads();
    bus.start = 1'b1;
    bus.thread_count = 8'd0;
    step();
    vectors++;
    if (bus.done !== 1'b1 || bus.core_reset !== 2'b00 || bus.core_start !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_fin: got done=%b rst=%b st=%b required done=1 rst=00 st=00",
               bus.done, bus.core_reset, bus.core_start);
    end
    step();
    vectors++;
    if (bus.done !== 1'b1 || bus.core_reset !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_hold: got done=%b rst=%b required done=1 rst=00", bus.done, bus.core_reset);
    end
    bus.start = 1'b0;
    step();
    vectors++;
    if (bus.done !== 1'b0 || bus.core_reset !== 2'b00 || bus.core_start !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_idle: got done=%b rst=%b st=%b required 0 00 00",
               bus.done, bus.core_reset, bus.core_start);
    end
  endtask

  task automatic test_ignored_done();
    bus.core_done = 2'b11;
    step();
    step();
    vectors++;
    if (bus.done !== 1'b0 || bus.core_start !== 2'b00) begin
      miscompares++;
      $display("FAIL ign_idle: got done=%b st=%b required done=0 st=00", bus.done, bus.core_start);
    end
    bus.core_done = 2'b10;
    launch(8'd8);
    step();
    step();
    vectors++;
    if (bus.core_reset !== 2'b10 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL ign_reset: got rst=%b done=%b required rst=10 done=0", bus.core_reset, bus.done);
    end
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.core_start !== 2'b11) begin
      miscompares++;
      $display("FAIL ign_run: got st=%b required 11", bus.core_start);
    end
    bus.core_done = 2'b11;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.done !== 1'b1 || bus.core_start !== 2'b00) begin
      miscompares++;
      $display("FAIL ign_done: got done=%b st=%b required done=1 st=00", bus.done, bus.core_start);
    end
    step();
  endtask

  task automatic test_mid_reset();
    launch(8'd8);
    step();
    step();
    step();
    vectors++;
    if (bus.core_start !== 2'b11) begin
      miscompares++;
      $display("FAIL mrst_pre: got st=%b required 11", bus.core_start);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    vectors++;
    if ({bus.done, bus.core_reset, bus.core_start, bus.core_block_id, bus.core_thread_count} !== 27'b0) begin
      miscompares++;
      $display("FAIL mrst_clear: got %h required 0",
               {bus.done, bus.core_reset, bus.core_start, bus.core_block_id, bus.core_thread_count});
    end
    launch(8'd8);
    step();
    vectors++;
    if (bus.core_reset !== 2'b01 || bus.core_block_id[0] !== 8'd0 || bus.core_thread_count[0] !== 3'd4) begin
      miscompares++;
      $display("FAIL mrst_restart: got rst=%b id=%0d cnt=%0d required rst=01 id=0 cnt=4",
               bus.core_reset, bus.core_block_id[0], bus.core_thread_count[0]);
    end
    step();
    step();
    bus.core_done = 2'b11;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL mrst_done: got done=%b required 1", bus.done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    launch(8'd12);
    step();
    step();
    step();
    bus.core_done = 2'b11;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.core_start !== 2'b00 || bus.core_reset !== 2'b00 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_free: got st=%b rst=%b done=%b required 00 00 0",
               bus.core_start, bus.core_reset, bus.done);
    end
    step();
    vectors++;
    if (bus.core_reset !== 2'b01 || bus.core_block_id[0] !== 8'd2 || bus.core_thread_count[0] !== 3'd4) begin
      miscompares++;
      $display("FAIL b2b_blk2: got rst=%b id=%0d cnt=%0d required rst=01 id=2 cnt=4",
               bus.core_reset, bus.core_block_id[0], bus.core_thread_count[0]);
    end
    step();
    vectors++;
    if (bus.core_start !== 2'b01 || bus.core_reset !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_run: got st=%b rst=%b required st=01 rst=00", bus.core_start, bus.core_reset);
    end
    bus.core_done = 2'b01;
    step();
    bus.core_done = 2'b00;
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: got done=%b required 1", bus.done);
    end
    step();
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got done=%b required 0", bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_full_blocks();
    test_partial_block();
    test_zero_threads();
    test_ignored_done();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
